// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
// Module   : d_latch
// Purpose  : Enabled data-holding register with capture status. When en is
//            high the input word is captured on the rising clock edge; when
//            en is low the last captured word is held. Status reports whether
//            any capture has happened since reset, whether the most recent
//            edge captured a word different from the one held before it, and
//            a saturating count of captures.
// Ports    : clk        - system clock, all state changes on rising edge
//            rst        - asynchronous active-low reset
//            en         - capture enable, sampled on rising clk
//            dataIn     - word to capture            [WIDTH-1:0]
//            dataOut    - held word (registered)      [WIDTH-1:0]
//            dataValid  - at least one capture since reset
//            changed    - one-cycle pulse after a capture that altered dataOut
//            capCount   - saturating capture counter  [CNT_WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module d_latch #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     dataIn,
  output logic [WIDTH-1:0]     dataOut,
  output logic                 dataValid,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] capCount
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     r_data;
  logic                 r_valid;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_differs;
  logic [CNT_WIDTH-1:0] w_count_next;

  // Compare against the word held before this edge, so the first capture
  // after reset is measured against the reset value of zero.
  assign w_differs = (dataIn != r_data);

  // Counter sticks at all-ones instead of wrapping.
  assign w_count_next = (r_count == c_cnt_max) ? r_count : (r_count + c_cnt_one);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_count   <= '0;
    end else if (en) begin
      r_data    <= dataIn;
      r_valid   <= 1'b1;
      r_changed <= w_differs;
      r_count   <= w_count_next;
    end else begin
      // Holding: only the change pulse needs to fall back.
      r_changed <= 1'b0;
    end
  end

  // Every output is a flop: no combinational input-to-output path.
  assign dataOut   = r_data;
  assign dataValid = r_valid;
  assign changed   = r_changed;
  assign capCount  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_latch
// Purpose  : Scoreboard bench for d_latch. Two instances share stimulus: one
//            with the default 8-bit counter and one with a 2-bit counter so
//            saturation is reached quickly. A reference model predicts the
//            outputs after every clock edge and every reset assertion; a
//            monitor pops those predictions and compares them with the DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_latch;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] dataIn;

  logic [WIDTH-1:0] dout_a;
  logic             valid_a;
  logic             chg_a;
  logic [7:0]       cnt_a;

  logic [WIDTH-1:0] dout_b;
  logic             valid_b;
  logic             chg_b;
  logic [1:0]       cnt_b;

  d_latch #(.WIDTH(WIDTH), .CNT_WIDTH(8)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dataIn    (dataIn),
    .dataOut   (dout_a),
    .dataValid (valid_a),
    .changed   (chg_a),
    .capCount  (cnt_a)
  );

  d_latch #(.WIDTH(WIDTH), .CNT_WIDTH(2)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dataIn    (dataIn),
    .dataOut   (dout_b),
    .dataValid (valid_b),
    .changed   (chg_b),
    .capCount  (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct {
    int data;
    int valid;
    int chg;
    int cnt8;
    int cnt2;
  } exp_t;

  exp_t exp_q[$];

  int m_word;
  int m_valid;
  int m_chg;
  int m_captures;

  int total = 0;
  int bad   = 0;

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // One prediction per observable event: a rising clk edge or a reset fall.
  always @(posedge clk or negedge rst) begin
    exp_t e;
    if (!rst) begin
      m_word     = 0;
      m_valid    = 0;
      m_chg      = 0;
      m_captures = 0;
    end else if (en) begin
      m_chg      = (int'(dataIn) != m_word) ? 1 : 0;
      m_word     = int'(dataIn);
      m_valid    = 1;
      m_captures = m_captures + 1;
    end else begin
      m_chg = 0;
    end
    e.data  = m_word;
    e.valid = m_valid;
    e.chg   = m_chg;
    e.cnt8  = sat(m_captures, 255);
    e.cnt2  = sat(m_captures, 3);
    exp_q.push_back(e);
  end

  // -------------------------------------------------------------- monitor
  task automatic check(input string name, input logic [31:0] act, input int expv);
    total = total + 1;
    if (act !== 32'(expv)) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    exp_t e;
    #1;
    total = total + 1;
    if (exp_q.size() == 0) begin
      bad = bad + 1;
      $display("FAIL queue_underflow at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      check("dataOut8",   32'(dout_a),  e.data);
      check("dataValid8", 32'(valid_a), e.valid);
      check("changed8",   32'(chg_a),   e.chg);
      check("capCount8",  32'(cnt_a),   e.cnt8);
      check("dataOut2",   32'(dout_b),  e.data);
      check("dataValid2", 32'(valid_b), e.valid);
      check("changed2",   32'(chg_b),   e.chg);
      check("capCount2",  32'(cnt_b),   e.cnt2);
    end
  end

  // ------------------------------------------------------------- stimulus
  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic step(input logic e_in, input logic [WIDTH-1:0] d_in);
    @(negedge clk);
    en     = e_in;
    dataIn = d_in;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    dataIn = '0;
    #2 rst = 1'b0;          // reset with en=0, dataIn=0 for > 10 ns
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    en     = 1'b1;
    dataIn = 4'b0101;

    // Tracking: two new values, each held across two edges.
    step(1'b1, 4'b0101);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b1100);

    // Hold: input churns but enable is low.
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);

    // Re-enable with a new word, then drop enable.
    step(1'b1, 4'b0001);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0110);

    // Glitches between edges must not matter.
    @(negedge clk);
    en = 1'b0; dataIn = 4'b0011;
    #1 en = 1'b1; dataIn = 4'b1001;
    #2 en = 1'b0; dataIn = 4'b0011;
    step(1'b0, 4'b0011);

    // Reset in the middle of a capture phase.
    step(1'b1, 4'b1010);
    #2 rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;      // next edge (en=1) captures 1010
    step(1'b1, 4'b1010);
    step(1'b0, 4'b1010);

    // First capture after reset is zero: changed stays low, valid rises.
    apply_reset();
    en = 1'b1; dataIn = 4'b0000;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0111);

    // Random traffic.
    for (int i = 0; i < 120; i++)
      step(($urandom % 4) != 0, WIDTH'($urandom));

    // Continuous capture long enough to saturate the 8-bit counter.
    for (int i = 0; i < 280; i++)
      step(1'b1, WIDTH'($urandom));

    // Saturated counters: captures still update data and changed.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);
    step(1'b0, 4'b0101);
    step(1'b0, 4'b0101);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
